// File: rtl/wlm_domain_pkg.sv
// Shared definitions for the Montgomery domain-entry block (wlm_domain_in).
// Holds the controller state encoding and a latency helper so that
// surrounding logic can size delay lines without duplicating the formula.
package wlm_domain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } wlm_state_e;

    // Cycles from the handshake cycle to the first cycle with out_valid high.
    function automatic int wlm_domain_in_lat(input int shift, input bit prered);
        return shift + 1 + (prered ? 1 : 0);
    endfunction

endpackage

// File: rtl/wlm_domain_in_moddbl.sv
// Combinational modular doubler: y = w - q if w >= q else w, where
// w = 2x (dbl=1) or w = x (dbl=0, used for the one-shot pre-reduction).
// The modulus is q = qh * 2^(LOGQ-LOGQH) + 1.
module moddbl #(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 15
) (
    input  logic [LOGQ-1:0]  x,
    input  logic [LOGQH-1:0] qh,
    input  logic             dbl,
    output logic [LOGQ-1:0]  y
);

    localparam int LOWW = LOGQ - LOGQH;

    logic [LOGQ-1:0] q;
    logic [LOGQ:0]   w;
    logic [LOGQ-1:0] d;

    // Build q, form the LOGQ+1-bit candidate and conditionally subtract q;
    // the difference always fits in LOGQ bits because w < 2q.
    always_comb begin
        q = {qh, {LOWW{1'b0}}} | LOGQ'(1);
        w = dbl ? {x, 1'b0} : {1'b0, x};
        d = w[LOGQ-1:0] - q;
        y = (w >= {1'b0, q}) ? d : w[LOGQ-1:0];
    end

endmodule

// File: rtl/wlm_domain_in.sv
// wlm_domain_in: converts A into the Montgomery domain, T = A*2^SHIFT mod q,
// by SHIFT iterated modular doublings (one per cycle).
// Optional build macro WLM_DOMAIN_IN_PRERED_EN adds a PRE state that reduces
// A once (x >= q -> x - q) so any A < 2^LOGQ is accepted; latency grows by 1.
module wlm_domain_in
    import wlm_domain_pkg::*;
#(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 15,
    parameter int SHIFT = 2 * (LOGQ - LOGQH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQH-1:0] qH,
    input  logic [LOGQ-1:0]  A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  T
);

    localparam int CW = (SHIFT > 0) ? $clog2(SHIFT + 1) : 1;

    wlm_state_e      state;
    logic [CW-1:0]   cnt;
    logic [LOGQ-1:0] x;
    logic [LOGQH-1:0] qh_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [LOGQ-1:0] x_next;
    logic            dbl;

`ifdef WLM_DOMAIN_IN_PRERED_EN
    assign dbl = (state != PRE);
`else
    assign dbl = 1'b1;
`endif

    moddbl #(
        .LOGQ  (LOGQ),
        .LOGQH (LOGQH)
    ) u_moddbl (
        .x   (x),
        .qh  (qh_r),
        .dbl (dbl),
        .y   (x_next)
    );

    // Controller and accumulator: accept, optionally pre-reduce, double SHIFT
    // times, then hold the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            x           <= '0;
            qh_r        <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x          <= A;
                        qh_r       <= qH;
                        cnt        <= CW'(SHIFT);
                        in_ready_r <= 1'b0;
`ifdef WLM_DOMAIN_IN_PRERED_EN
                        state      <= PRE;
`else
                        if (SHIFT == 0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
`ifdef WLM_DOMAIN_IN_PRERED_EN
                PRE: begin
                    x <= x_next;
                    if (SHIFT == 0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
`endif
                RUN: begin
                    x   <= x_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign T         = out_valid_r ? x : '0;

endmodule
